// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO register pair with iterative 32-cycle multiply/divide engine
// Optional macro HILO_BYPASS_EN forwards same-cycle MTHI/MTLO data onto hi_rd/lo_rd.
module hilo_muldiv #(
    parameter logic [31:0] HI_RST_VAL = 32'h0000_0000,
    parameter logic [31:0] LO_RST_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        wr_hi_en,
    input  logic [31:0] wr_hi_data,
    input  logic        wr_lo_en,
    input  logic [31:0] wr_lo_data,
    output logic [31:0] hi_rd,
    output logic [31:0] lo_rd,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic        b_zero_q, b_zero_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] work_q, work_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic        in_signed;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic [32:0] div_trial;
    logic        neg_res;
    logic [63:0] mul_res;
    logic [31:0] quo_res, rem_res;

    assign in_signed = ~op[0];
    assign abs_a     = (in_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign abs_b     = (in_signed && src_b[31]) ? (32'd0 - src_b) : src_b;

    // work_q holds {partial product, multiplier} for MULT and {remainder, quotient} for DIV
    assign mul_sum   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, a_q} : 33'd0);
    assign rem_sh    = work_q[63:31];
    assign div_trial = rem_sh - {1'b0, b_q};

    assign neg_res = ~op_q[0] & (sign_a_q ^ sign_b_q);
    assign mul_res = neg_res ? (64'd0 - work_q) : work_q;
    assign quo_res = neg_res ? (32'd0 - work_q[31:0]) : work_q[31:0];
    assign rem_res = (~op_q[0] & sign_a_q) ? (32'd0 - work_q[63:32]) : work_q[63:32];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        b_zero_d = b_zero_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    state_d  = RUN;
                    op_d     = op;
                    a_d      = abs_a;
                    b_d      = abs_b;
                    sign_a_d = in_signed & src_a[31];
                    sign_b_d = in_signed & src_b[31];
                    b_zero_d = (src_b == 32'd0);
                    cnt_d    = 5'd0;
                    work_d   = op[1] ? {32'd0, abs_a} : {32'd0, abs_b};
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    if (op_q[1]) begin
                        // restoring step: keep the trial difference only when it did not borrow
                        if (!div_trial[32]) begin
                            work_d = {div_trial[31:0], work_q[30:0], 1'b1};
                        end else begin
                            work_d = {rem_sh[31:0], work_q[30:0], 1'b0};
                        end
                    end else begin
                        work_d = {mul_sum, work_q[31:1]};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (op_q[1] && b_zero_q) begin
                        dbz_d = 1'b1;
                    end else if (op_q[1]) begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end else begin
                        hi_d = mul_res[63:32];
                        lo_d = mul_res[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // committed MTHI/MTLO come from a younger instruction, so they override the engine
        if (wr_hi_en) begin
            hi_d = wr_hi_data;
        end
        if (wr_lo_en) begin
            lo_d = wr_lo_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            op_q     <= 2'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            cnt_q    <= 5'd0;
            work_q   <= 64'd0;
            hi_q     <= HI_RST_VAL;
            lo_q     <= LO_RST_VAL;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_zero_q <= b_zero_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = ((state_q == IDLE) && start && !flush) || (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

`ifdef HILO_BYPASS_EN
    assign hi_rd = wr_hi_en ? wr_hi_data : hi_q;
    assign lo_rd = wr_lo_en ? wr_lo_data : lo_q;
`else
    assign hi_rd = hi_q;
    assign lo_rd = lo_q;
`endif

endmodule
